pc_fetch_vic: RTL
=================

Name: pc_fetch_vic

Overview:
- Parametrised successor to the microprocessor's top-level PC register.
- Owns the program counter and the registered instruction fetch, and adds a vectored, prioritised, nestable interrupt controller with a hardware return-address stack.
- Sits between the instruction memory and the non-pipelined core: it drives the fetch address, latches the instruction word, and redirects the PC on interrupt entry and exit.

Parameters:
- PC_W, 4: program counter and instruction address width.
- IR_W, 16: instruction word width.
- NUM_IRQ, 4: number of interrupt request lines.
- VEC_BASE, 8: address of the vector for irq[0].
- VEC_STRIDE, 2: address spacing between consecutive vectors.
- STACK_DEPTH, 2: maximum interrupt nesting depth (return-stack entries).

Ports:
- clk  in  1  : system clock, all state on the rising edge.
- rst  in  1  : synchronous, active-low reset.
- stall  in  1  : hold PC, IR and the stack.
- pc_load  in  1  : branch/jump request from the core.
- pc_target  in  PC_W  : branch destination.
- reti  in  1  : return-from-interrupt request.
- int_en  in  1  : global interrupt enable.
- irq  in  NUM_IRQ  : interrupt requests; index 0 has the highest priority.
- imem_addr  out  PC_W  : fetch address, always equal to the PC register.
- imem_data  in  IR_W  : instruction word, combinational read of imem_addr.
- ir  out  IR_W  : registered instruction.
- ir_valid  out  1  : ir holds a real instruction (0 = bubble).
- irq_ack  out  NUM_IRQ  : one-hot, 1-cycle pulse in the cycle the vector loads.
- isr_level  out  $clog2(STACK_DEPTH+1)  : current nesting depth.
- stack_err  out  1  : sticky flag, set by reti with an empty stack.

Behaviour:
- Reset (rst==0 at posedge) forces:
  - pc=0, ir=0, ir_valid=0, irq_ack=0, isr_level=0, stack_err=0.
  - Stack and priority entries cleared.
  - Reset mid-ISR discards all nesting.
- Current priority cp = priority index stored at the stack top, or NUM_IRQ when the stack is empty.
- Interrupt candidate k = lowest set index of the active requests.
- Take condition: int_en && k<cp && isr_level<STACK_DEPTH.
- Per-cycle priority (exactly one action):
  1. stall: everything holds; irq_ack=0; requests are not lost (level or pending).
  2. reti:
     - Stack non-empty: pc<=popped address, ir_valid<=0 (bubble), isr_level-1.
     - Stack empty: pc<=pc+1, stack_err<=1, ir<=imem_data, ir_valid<=1.
     - Any interrupt in the same cycle is deferred to the next cycle.
  3. Take:
     - Push return address = pc_load ? pc_target : pc, together with priority k.
     - pc<=(VEC_BASE+k*VEC_STRIDE) mod 2^PC_W.
     - ir<=0, ir_valid<=0.
     - irq_ack[k]<=1 for one cycle; isr_level+1.
  4. pc_load: pc<=pc_target; ir<=imem_data; ir_valid<=1.
  5. Otherwise: pc<=(pc+1) mod 2^PC_W, i.e. 2^PC_W-1 wraps to 0; ir<=imem_data; ir_valid<=1.
- Latency: the IRQ sampled at edge N puts the vector on imem_addr after edge N; the first ISR instruction appears in ir after edge N+1.
- Requests with k>=cp are held, not dropped. Requests are masked while isr_level==STACK_DEPTH, so the stack cannot overflow.
- FSM: RUN/BUBBLE is implied by ir_valid. No multi-cycle states besides stall.
- irq_ack is never asserted in two consecutive cycles for the same vector unless the take condition is re-met.

Optional Feature:
- Macro: IRQ_LATCH_EN.
- Defined:
  - A rising edge on irq[i] (registered previous value) sets pending[i].
  - The take logic uses the pending bits; pending[k] clears on its irq_ack.
  - Edges during stall are still latched.
  - Reset clears pending and the edge-detection history.
- Undefined:
  - Level-sensitive; the take logic uses irq directly.
  - The source must hold irq until irq_ack.

Test Plan:
1. Reset then run, with rst=0 for 2 cycles then 1 and imem_data=pc*3 → pc steps 0,1,…,15,0; ir lags pc by one cycle; ir_valid=1 from the first post-reset edge.
2. At pc=5 with int_en=1, raise irq=4'b0100 → next pc=12, irq_ack=4'b0100 for 1 cycle, ir_valid=0, isr_level=1. reti at pc=13 → pc=5, isr_level=0.
3. Nesting: in the irq[2] ISR at pc=12, raise irq[3] → ignored. Raise irq[0] → pc=8, isr_level=2. A further irq[1] → masked (stack full). Two retis → return to 13, then to 5.
4. Simultaneous: pc_load=1, pc_target=3 with irq[1] → pc=10 and pushed address 3. reti and irq[0] together → pop first, irq[0] taken the next cycle.
5. reti with isr_level=0 → stack_err=1, which persists until rst=0. stall=1 for 3 cycles with irq[0] → no ack, pc held; ack in the first cycle after stall drops.
6. IRQ_LATCH_EN defined: 1-cycle irq[3] pulse during stall → pending, taken after stall (pc=14). Same test without the macro → not taken.

Source files
------------

// File: rtl/pc_fetch_vic.sv
// pc_fetch_vic: program counter, registered instruction fetch and a vectored,
// prioritised, nestable interrupt controller with a hardware return stack.
//
// Optional build macro IRQ_LATCH_EN:
//   defined   - irq lines are edge-latched into pending bits that clear on ack
//   undefined - irq lines are level-sensitive and must be held until irq_ack
module pc_fetch_vic #(
  parameter int PC_W        = 4,
  parameter int IR_W        = 16,
  parameter int NUM_IRQ     = 4,
  parameter int VEC_BASE    = 8,
  parameter int VEC_STRIDE  = 2,
  parameter int STACK_DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               stall,
  input  logic                               pc_load,
  input  logic [PC_W-1:0]                    pc_target,
  input  logic                               reti,
  input  logic                               int_en,
  input  logic [NUM_IRQ-1:0]                 irq,
  output logic [PC_W-1:0]                    imem_addr,
  input  logic [IR_W-1:0]                    imem_data,
  output logic [IR_W-1:0]                    ir,
  output logic                               ir_valid,
  output logic [NUM_IRQ-1:0]                 irq_ack,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   isr_level,
  output logic                               stack_err
);

  localparam int LVL_W = $clog2(STACK_DEPTH + 1);
  // Wide enough to hold NUM_IRQ itself, the "no ISR active" priority.
  localparam int PRI_W = $clog2(NUM_IRQ + 1);

  // One return-stack entry: where to resume and the priority being served.
  typedef struct packed {
    logic [PC_W-1:0]  addr;
    logic [PRI_W-1:0] pri;
  } stk_ent_t;

  stk_ent_t [STACK_DEPTH-1:0] stk;

  logic [PC_W-1:0]    pc;
  logic [NUM_IRQ-1:0] req;
  logic [PRI_W-1:0]   cp;
  logic [PC_W-1:0]    pop_addr;
  logic [PRI_W-1:0]   k;
  logic               found;
  logic               take;
  logic [PC_W-1:0]    vec_addr;
  logic [NUM_IRQ-1:0] ack_mask;
  logic [PC_W-1:0]    ret_addr;

  assign imem_addr = pc;

`ifdef IRQ_LATCH_EN
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] take_clr;

  assign rise     = irq & ~irq_q;
  // A fresh edge is visible to the take logic in the same cycle, so latching
  // adds no latency over level mode.
  assign req      = pending | rise;
  assign take_clr = (!stall && !reti && take) ? ack_mask : '0;

  // Edge history and pending bits keep updating through stall so no pulse is lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      irq_q   <= '0;
      pending <= '0;
    end else begin
      irq_q   <= irq;
      pending <= (pending | rise) & ~take_clr;
    end
  end
`else
  assign req = irq;
`endif

  // Current priority and return address come from the top of the stack.
  always_comb begin
    cp       = PRI_W'(NUM_IRQ);
    pop_addr = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (isr_level == LVL_W'(i + 1)) begin
        cp       = stk[i].pri;
        pop_addr = stk[i].addr;
      end
    end
  end

  // Lowest set request index wins (index 0 is the most urgent).
  always_comb begin
    k     = '0;
    found = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        k     = PRI_W'(i);
        found = 1'b1;
      end
    end
  end

  assign take     = int_en && found && (k < cp) && (isr_level < LVL_W'(STACK_DEPTH));
  // Arithmetic is done at PC_W bits, which is exactly the mod 2^PC_W wrap.
  assign vec_addr = PC_W'(VEC_BASE) + PC_W'(k) * PC_W'(VEC_STRIDE);
  assign ack_mask = NUM_IRQ'(1) << k;
  // A branch in the take cycle must not be lost: resume at its target.
  assign ret_addr = pc_load ? pc_target : pc;

  // PC / IR / stack update, one action per cycle in priority order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc        <= '0;
      ir        <= '0;
      ir_valid  <= 1'b0;
      irq_ack   <= '0;
      isr_level <= '0;
      stack_err <= 1'b0;
      stk       <= '0;
    end else if (stall) begin
      irq_ack <= '0;
    end else if (reti) begin
      irq_ack <= '0;
      if (isr_level != '0) begin
        pc        <= pop_addr;
        ir        <= '0;
        ir_valid  <= 1'b0;
        isr_level <= isr_level - LVL_W'(1);
      end else begin
        pc        <= pc + PC_W'(1);
        ir        <= imem_data;
        ir_valid  <= 1'b1;
        stack_err <= 1'b1;
      end
    end else if (take) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (isr_level == LVL_W'(i)) stk[i] <= '{addr: ret_addr, pri: k};
      end
      pc        <= vec_addr;
      ir        <= '0;
      ir_valid  <= 1'b0;
      irq_ack   <= ack_mask;
      isr_level <= isr_level + LVL_W'(1);
    end else if (pc_load) begin
      irq_ack  <= '0;
      pc       <= pc_target;
      ir       <= imem_data;
      ir_valid <= 1'b1;
    end else begin
      irq_ack  <= '0;
      pc       <= pc + PC_W'(1);
      ir       <= imem_data;
      ir_valid <= 1'b1;
    end
  end

endmodule
